// File: rtl/seq_adder.sv
// Multi-cycle ripple adder/subtractor: SLICE bits per clock through a full-adder
// chain, slice carry held in a register, start/done handshake.
module seq_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

   if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("seq_adder: WIDTH must be a multiple of SLICE with 1 <= SLICE <= WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   int               base;
   logic [SLICE-1:0] sa, sb, ss;
   logic [SLICE:0]   c;

   assign base = SLICE * int'(cnt);
   assign sa   = op_a[base +: SLICE];
   assign sb   = op_b[base +: SLICE];
   assign c[0] = carry;

   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      assign ss[i]   = sa[i] ^ sb[i] ^ c[i];
      assign c[i+1]  = (sa[i] & sb[i]) | (c[i] & (sa[i] ^ sb[i]));
   end

   always_comb begin
      acc_nxt = acc;
      acc_nxt[base +: SLICE] = ss;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         cnt   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  // subtract is a + ~b + ~cin, so invert once at capture
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= cin ^ sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= c[SLICE];
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(NSL - 1)) begin
                  // last slice holds the operand MSBs in its top bit
                  sum   <= acc_nxt;
                  cout  <= c[SLICE];
                  ovf   <= (sa[SLICE-1] == sb[SLICE-1]) && (ss[SLICE-1] != sa[SLICE-1]);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder: directed cases on 16/4, random sweep over
// several WIDTH/SLICE configurations against an arithmetic reference.
module tb_seq_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int fin   = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int unsigned t;
   } exp_t;

   localparam int NCFG = 6;
   localparam int CFG_W [NCFG] = '{16, 16, 16, 16, 16, 1};
   localparam int CFG_S [NCFG] = '{4, 1, 2, 8, 16, 1};

   task automatic chk(int g, string nm, logic [63:0] act, logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL cfg%0d %s got=%0h want=%0h", g, nm, act, want);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
      exp_t   e;
      longint m  = longint'(1) << w;
      longint ua = longint'(a) & (m - 1);
      longint ub = longint'(b) & (m - 1);
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint u, r;
      if (!sub) begin
         u = ua + ub + longint'(cin);
         r = sa + sb + longint'(cin);
      end else begin
         u = ua - ub - longint'(cin) + m;
         r = sa - sb - longint'(cin);
      end
      e.sum  = 16'(u % m);
      e.cout = (u >= m);
      e.ovf  = (r < -(m / 2)) || (r >= m / 2);
      e.t    = 0;
      return e;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W   = CFG_W[g];
      localparam int S   = CFG_S[g];
      localparam int NSL = W / S;

      logic         rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
      logic [W-1:0] a = '0, b = '0, sum;
      logic         busy, done, cout, ovf;
      exp_t         q[$];
      exp_t         hd = '{sum: '0, cout: 1'b0, ovf: 1'b0, t: 0};
      int           bcnt = 0;

      seq_adder #(.WIDTH(W), .SLICE(S)) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
         .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
      );

      always @(negedge clk) begin
         if (!rst_n) begin
            hd.sum = '0; hd.cout = 1'b0; hd.ovf = 1'b0;
            bcnt = 0;
         end else if (done) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL cfg%0d unexpected_done got=%0h want=none", g, sum);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk(g, "sum", 64'(sum), 64'(e.sum));
               chk(g, "cout", 64'(cout), 64'(e.cout));
               chk(g, "ovf", 64'(ovf), 64'(e.ovf));
               chk(g, "latency", 64'(cyc - e.t), 64'(NSL + 1));
               chk(g, "busy_cycles", 64'(bcnt), 64'(NSL));
               chk(g, "busy_at_done", 64'(busy), 64'(0));
               hd = e;
            end
            bcnt = 0;
         end else begin
            if (busy) bcnt++;
            chk(g, "hold_sum", 64'(sum), 64'(hd.sum[W-1:0]));
            chk(g, "hold_cout", 64'(cout), 64'(hd.cout));
            chk(g, "hold_ovf", 64'(ovf), 64'(hd.ovf));
         end
      end

      task automatic issue(logic [W-1:0] ia, logic [W-1:0] ib, logic ic, logic is);
         a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      endtask

      task automatic push(exp_t e, int unsigned t);
         e.t = t;
         q.push_back(e);
      endtask

      task automatic wait_done();
         int k = 0;
         while (!done && k < NSL + 8) begin
            @(posedge clk); #1;
            k++;
         end
         if (!done) begin
            tests++; fails++;
            $display("FAIL cfg%0d done_timeout got=0 want=1", g);
         end
      endtask

      task automatic run_random(int n);
         for (int i = 0; i < n; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            push(model(W, 16'(a), 16'(b), cin, sub), cyc);
            @(posedge clk); #1;
            // operands scrambled and a stray start while the op is in flight
            start = 1'($urandom);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
               repeat ($urandom_range(1, 2)) begin
                  @(posedge clk); #1;
               end
            end
         end
      endtask

      task automatic finish_cfg();
         @(negedge clk); #1;
         chk(g, "pending", 64'(q.size()), 64'(0));
         fin++;
      endtask

      if (g == 0) begin : g_dir
         task automatic vec(logic [15:0] va, logic [15:0] vb, logic vc, logic vs,
                            logic [15:0] es, logic ec, logic eo);
            exp_t e;
            e.sum = es; e.cout = ec; e.ovf = eo; e.t = 0;
            issue(W'(va), W'(vb), vc, vs);
            push(e, cyc);
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
            @(posedge clk); #1;
         endtask

         initial begin
            exp_t e;
            int unsigned t0;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "rst_busy", 64'(busy), 64'(0));
            chk(g, "rst_done", 64'(done), 64'(0));
            chk(g, "rst_sum", 64'(sum), 64'(0));
            chk(g, "rst_cout", 64'(cout), 64'(0));
            chk(g, "rst_ovf", 64'(ovf), 64'(0));
            rst_n = 1'b1;
            @(posedge clk); #1;

            vec(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
            vec(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
            vec(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            vec(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

            // start during RUN with other operands must not disturb the result
            issue(W'(16'h1234), W'(16'h4321), 1'b0, 1'b0);
            e.sum = 16'h5555; e.cout = 1'b0; e.ovf = 1'b0;
            push(e, cyc);
            @(posedge clk); #1;
            issue(W'(16'hFFFF), W'(16'hFFFF), 1'b1, 1'b1);
            repeat (2) begin
               @(posedge clk); #1;
            end
            start = 1'b0;
            wait_done();
            @(posedge clk); #1;

            // start held high: acceptances every NSL+1 cycles
            issue(W'(16'h0001), W'(16'h0002), 1'b1, 1'b0);
            t0 = cyc;
            e.sum = 16'h0004; e.cout = 1'b0; e.ovf = 1'b0;
            for (int k = 0; k < 3; k++) push(e, t0 + k * (NSL + 1));
            wait_done();
            @(posedge clk); #1;
            wait_done();
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
            @(posedge clk); #1;

            // reset in the second RUN cycle aborts with no done pulse
            issue(W'(16'h1111), W'(16'h2222), 1'b0, 1'b0);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk(g, "abort_busy", 64'(busy), 64'(0));
            chk(g, "abort_done", 64'(done), 64'(0));
            chk(g, "abort_sum", 64'(sum), 64'(0));
            repeat (8) begin
               @(posedge clk); #1;
            end
            vec(16'h0100, 16'h00FF, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);

            run_random(1000);
            finish_cfg();
         end
      end else begin : g_rnd
         initial begin
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            run_random(1000);
            finish_cfg();
         end
      end
   end

   initial begin
      for (int k = 0; k < 60000 && fin < NCFG; k++) @(posedge clk);
      if (fin < NCFG) begin
         tests++; fails++;
         $display("FAIL run_timeout got=%0d want=%0d", fin, NCFG);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
